// File: rtl/picorv32_pcpi_mux_if.sv
// ---------------------------------------------------------------------------
// picorv32_pcpi_mux_if
// Core-side PCPI bundle between the picorv32 core and the co-processor mux.
//
// Handshake: the core raises pcpi_valid with a stable insn/rs1/rs2 and keeps
// it high until it sees pcpi_int_ready or pcpi_int_timeout (each a one-cycle
// strobe). Dropping pcpi_valid early abandons the request without a strobe.
// pcpi_int_wait means a co-processor has claimed the request and is working.
//
// Modports:
//   master - core side (drives the request, receives the result)
//   slave  - mux side  (receives the request, drives the result)
// ---------------------------------------------------------------------------
interface picorv32_pcpi_mux_if #(
  parameter int XLEN = 32
);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_int_wr;
  logic [XLEN-1:0] pcpi_int_rd;
  logic            pcpi_int_wait;
  logic            pcpi_int_ready;
  logic            pcpi_int_timeout;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_int_wr, pcpi_int_rd, pcpi_int_wait, pcpi_int_ready,
           pcpi_int_timeout
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_int_wr, pcpi_int_rd, pcpi_int_wait, pcpi_int_ready,
           pcpi_int_timeout
  );
endinterface

// File: rtl/picorv32_pcpi_mux.sv
// ---------------------------------------------------------------------------
// picorv32_pcpi_mux
// Registers a PCPI request from the core, broadcasts it to the channels
// selected by ch_enable (sampled at issue), and returns the first response
// (lowest-index ready channel wins) as a single pcpi_int_* result. Owns the
// PCPI timeout: TIMEOUT quiet cycles in ISSUE, or an empty mask, produce a
// one-cycle pcpi_int_timeout strobe.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pcpi              core-side request/result bundle (slave modport)
//   ch_enable         channel mask, sampled when a request is issued
//   ch_valid          per-channel request (mask while ISSUE/BUSY)
//   ch_insn/rs1/rs2   registered request, broadcast to all channels
//   ch_wr/wait/ready  per-channel responses
//   ch_rd             per-channel results, channel i at [i*XLEN +: XLEN]
//   err_multi         sticky protocol error (checker build only)
//   dbg_state_o       current FSM state
//
// Build option: define PCPI_MUX_CHECK_EN to enable the protocol checker
// behind err_multi; otherwise err_multi is tied low.
// ---------------------------------------------------------------------------
module picorv32_pcpi_mux #(
  parameter int NCH     = 4,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  picorv32_pcpi_mux_if.slave  pcpi,
  input  logic [NCH-1:0]      ch_enable,
  output logic [NCH-1:0]      ch_valid,
  output logic [31:0]         ch_insn,
  output logic [XLEN-1:0]     ch_rs1,
  output logic [XLEN-1:0]     ch_rs2,
  input  logic [NCH-1:0]      ch_wr,
  input  logic [NCH-1:0]      ch_wait,
  input  logic [NCH-1:0]      ch_ready,
  input  logic [NCH*XLEN-1:0] ch_rd,
  output logic                err_multi,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [31:0]     insn_q, insn_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            ready_q, ready_d;
  logic            timeout_q, timeout_d;
  logic            wait_q, wait_d;

  logic            active;
  logic [NCH-1:0]  rdy_m, wt_m;
  logic [IDXW-1:0] win;

  assign active = (state_q == ISSUE) || (state_q == BUSY);
  assign rdy_m  = ch_ready & mask_q;
  assign wt_m   = ch_wait & mask_q;

  // Fixed priority: scanning from the top down leaves the lowest index.
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rdy_m[i]) win = IDXW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    insn_d    = insn_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ready_d   = 1'b0;
    timeout_d = 1'b0;
    wait_d    = active && (|wt_m);

    case (state_q)
      IDLE: begin
        if (pcpi.pcpi_valid) begin
          insn_d = pcpi.pcpi_insn;
          rs1_d  = pcpi.pcpi_rs1;
          rs2_d  = pcpi.pcpi_rs2;
          mask_d = ch_enable;
          cnt_d  = '0;
          if (ch_enable == '0) begin
            // Nobody could ever claim it: report illegal instruction at once.
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!pcpi.pcpi_valid) begin
          state_d = IDLE;
        end else if (|rdy_m) begin
          // Ready beats both a same-cycle wait and the final timeout cycle.
          rd_d    = ch_rd[win*XLEN +: XLEN];
          wr_d    = ch_wr[win];
          ready_d = 1'b1;
          state_d = DONE;
        end else if (|wt_m) begin
          state_d = BUSY;
        end else if (cnt_q + CW'(1) == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BUSY: begin
        // A claimed request is never timed out; the channel owns it.
        if (!pcpi.pcpi_valid) begin
          state_d = IDLE;
        end else if (|rdy_m) begin
          rd_d    = ch_rd[win*XLEN +: XLEN];
          wr_d    = ch_wr[win];
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Hold here until the core retires the request, so it is not reissued.
        if (!pcpi.pcpi_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      insn_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      insn_q    <= insn_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

`ifdef PCPI_MUX_CHECK_EN
  logic err_q;
  logic multi_rdy, stray_rdy;

  // rdy_m & (rdy_m - 1) clears the lowest set bit; non-zero means >= 2 set.
  assign multi_rdy = (rdy_m & (rdy_m - NCH'(1))) != '0;
  assign stray_rdy = (ch_ready & ~mask_q) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (active && (multi_rdy || stray_rdy)) begin
      err_q <= 1'b1;
    end
  end

  assign err_multi = err_q;
`else
  assign err_multi = 1'b0;
`endif

  assign ch_valid              = active ? mask_q : '0;
  assign ch_insn               = insn_q;
  assign ch_rs1                = rs1_q;
  assign ch_rs2                = rs2_q;
  assign pcpi.pcpi_int_wr      = wr_q;
  assign pcpi.pcpi_int_rd      = rd_q;
  assign pcpi.pcpi_int_wait    = wait_q;
  assign pcpi.pcpi_int_ready   = ready_q;
  assign pcpi.pcpi_int_timeout = timeout_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_picorv32_pcpi_mux.sv
// ---------------------------------------------------------------------------
// tb_picorv32_pcpi_mux
// Directed and randomized requests for picorv32_pcpi_mux (NCH=4, XLEN=32,
// TIMEOUT=16). Each request is described by a per-cycle response schedule;
// a transaction-level model walks that schedule to predict result cycle,
// timeout cycle, winning result, wait profile and the sticky error flag.
// ---------------------------------------------------------------------------
module tb_picorv32_pcpi_mux;
  localparam int NCH     = 4;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int MAXC    = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd2;
`ifdef PCPI_MUX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  picorv32_pcpi_mux_if #(.XLEN(XLEN)) pcpi ();

  logic [NCH-1:0]      ch_enable, ch_valid, ch_wr, ch_wait, ch_ready;
  logic [31:0]         ch_insn;
  logic [XLEN-1:0]     ch_rs1, ch_rs2;
  logic [NCH*XLEN-1:0] ch_rd;
  logic                err_multi;
  logic [1:0]          dbg_state;

  picorv32_pcpi_mux #(.NCH(NCH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pcpi(pcpi),
    .ch_enable(ch_enable), .ch_valid(ch_valid), .ch_insn(ch_insn),
    .ch_rs1(ch_rs1), .ch_rs2(ch_rs2), .ch_wr(ch_wr), .ch_wait(ch_wait),
    .ch_ready(ch_ready), .ch_rd(ch_rd), .err_multi(err_multi),
    .dbg_state_o(dbg_state)
  );

  // ---- scoreboard state ----
  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];
  bit              exp_wr_q[$];
  bit              exp_err;
  logic [NCH-1:0]  rdy_a[0:MAXC+2];
  logic [NCH-1:0]  wt_a[0:MAXC+2];
  logic [XLEN-1:0] rdv[NCH];
  logic [NCH-1:0]  wrv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle_channels();
    ch_wait  = '0;
    ch_ready = '0;
    ch_wr    = '0;
    for (int i = 0; i < NCH; i++) ch_rd[i*XLEN +: XLEN] = rdv[i];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_chvalid"}, 64'(ch_valid), 64'd0);
    chk({tag, "_ready"}, 64'(pcpi.pcpi_int_ready), 64'd0);
    chk({tag, "_timeout"}, 64'(pcpi.pcpi_int_timeout), 64'd0);
    chk({tag, "_wait"}, 64'(pcpi.pcpi_int_wait), 64'd0);
    chk({tag, "_wr"}, 64'(pcpi.pcpi_int_wr), 64'd0);
    chk({tag, "_rd"}, 64'(pcpi.pcpi_int_rd), 64'd0);
    chk({tag, "_insn"}, 64'(ch_insn), 64'd0);
    chk({tag, "_rs1"}, 64'(ch_rs1), 64'd0);
    chk({tag, "_rs2"}, 64'(ch_rs2), 64'd0);
    chk({tag, "_err"}, 64'(err_multi), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // One request. Called one step after an edge with the mux idle.
  //  m: channel mask, r: cycle of masked ready (0 = none),
  //  w: first wait cycle (0 = none; waits run w..r-1), rset: ready channels,
  //  noise: sprinkle unmasked wait/ready and masked wait alongside ready.
  task automatic run_txn(input logic [NCH-1:0] m, input int r, input int w,
                         input logic [NCH-1:0] rset, input bit noise,
                         input logic [31:0] insn);
    logic [NCH-1:0] low;
    logic [XLEN-1:0] rs1v, rs2v;
    int end_c, rdy_c, to_c, cnt, win, n;
    bit busy, done;

    low = m & (~m + NCH'(1));
    for (int c = 0; c <= MAXC + 2; c++) begin
      rdy_a[c] = '0;
      wt_a[c]  = '0;
      if (c >= 1 && c <= MAXC) begin
        if (w != 0 && c >= w && c < r) wt_a[c] = (m & NCH'($urandom)) | low;
        if (c == r) begin
          rdy_a[c] = ((rset & m) != '0) ? (rset & m) : low;
          if (noise) wt_a[c] = m & NCH'($urandom);
        end
        if (noise && $urandom_range(0, 7) == 0) rdy_a[c] |= ~m & NCH'($urandom);
        if (noise && $urandom_range(0, 3) == 0) wt_a[c]  |= ~m & NCH'($urandom);
      end
    end

    // Reference model: walk the schedule cycle by cycle.
    end_c = 0; rdy_c = 0; to_c = 0; cnt = 0; busy = 0; done = 0; win = 0;
    if (m == '0) begin
      to_c = 1;
    end else begin
      for (int c = 1; c <= MAXC && !done; c++) begin
        if ((rdy_a[c] & m) != '0) begin
          for (int i = 0; i < NCH; i++) begin
            if (rdy_a[c][i] && m[i]) begin win = i; break; end
          end
          rdy_c = c + 1; end_c = c; done = 1;
        end else if ((wt_a[c] & m) != '0) begin
          busy = 1;
        end else if (!busy) begin
          cnt++;
          if (cnt == TIMEOUT) begin to_c = c + 1; end_c = c; done = 1; end
        end
      end
    end
    if (rdy_c != 0) begin
      exp_q.push_back(rdv[win]);
      exp_wr_q.push_back(wrv[win]);
    end

    // Issue in cycle 0.
    rs1v = XLEN'($urandom);
    rs2v = XLEN'($urandom);
    pcpi.pcpi_valid = 1'b1;
    pcpi.pcpi_insn  = insn;
    pcpi.pcpi_rs1   = rs1v;
    pcpi.pcpi_rs2   = rs2v;
    ch_enable       = m;
    drive_idle_channels();

    for (int c = 1; c <= end_c + 2; c++) begin
      tick();
      ch_enable = NCH'($urandom);   // only the value at issue may matter
      chk($sformatf("chvalid_c%0d", c), 64'(ch_valid), (c <= end_c) ? 64'(m) : 64'd0);
      chk($sformatf("ready_c%0d", c), 64'(pcpi.pcpi_int_ready), 64'(c == rdy_c));
      chk($sformatf("timeout_c%0d", c), 64'(pcpi.pcpi_int_timeout), 64'(c == to_c));
      chk($sformatf("wait_c%0d", c), 64'(pcpi.pcpi_int_wait),
          (c >= 2 && c - 1 <= end_c) ? 64'(|(wt_a[c-1] & m)) : 64'd0);
      chk($sformatf("err_c%0d", c), 64'(err_multi), 64'(exp_err));
      if (c == 1 && m != '0) begin
        chk("ch_insn", 64'(ch_insn), 64'(insn));
        chk("ch_rs1", 64'(ch_rs1), 64'(rs1v));
        chk("ch_rs2", 64'(ch_rs2), 64'(rs2v));
      end
      if (c == rdy_c) begin
        chk("int_rd", 64'(pcpi.pcpi_int_rd), 64'(exp_q.pop_front()));
        chk("int_wr", 64'(pcpi.pcpi_int_wr), 64'(exp_wr_q.pop_front()));
      end
      if (c <= end_c) begin
        ch_wait  = wt_a[c];
        ch_ready = rdy_a[c];
        ch_wr    = NCH'($urandom) & ~m | (wrv & m);
        n = 0;
        for (int i = 0; i < NCH; i++) n += int'(rdy_a[c][i] & m[i]);
        if (CHK && (n >= 2 || (rdy_a[c] & ~m) != '0)) exp_err = 1'b1;
      end else begin
        drive_idle_channels();
      end
      if (c == end_c + 2) pcpi.pcpi_valid = 1'b0;
    end
    tick();
    chk("back_to_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("idle_chvalid", 64'(ch_valid), 64'd0);
  endtask

  task automatic rand_rd();
    for (int i = 0; i < NCH; i++) rdv[i] = XLEN'($urandom);
    wrv = NCH'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    pcpi.pcpi_valid = 1'b0;
    pcpi.pcpi_insn  = '0;
    pcpi.pcpi_rs1   = '0;
    pcpi.pcpi_rs2   = '0;
    ch_enable = '0;
    exp_err   = 1'b0;
    rand_rd();
    drive_idle_channels();
    repeat (3) tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // Single channel, immediate result.
    rdv[1] = 32'h12345678; wrv = 4'b0010;
    run_txn(4'b0010, 1, 0, 4'b0010, 1'b0, 32'h02B50533);
    // Long claimed operation: waits 1..40, ready at 41.
    rand_rd();
    run_txn(4'b0100, 41, 1, 4'b0100, 1'b0, 32'h02C5C5B3);
    // Nobody answers: timeout in cycle TIMEOUT+1.
    run_txn(4'b1111, 0, 0, 4'b0000, 1'b0, 32'h0000000B);
    // Ready in the last timeout cycle beats the timeout.
    rand_rd();
    run_txn(4'b0011, TIMEOUT, 0, 4'b0010, 1'b0, 32'h0200000B);
    // Empty mask: immediate timeout.
    run_txn(4'b0000, 0, 0, 4'b0000, 1'b0, 32'h0400000B);
    // Two masked channels ready together: lowest index wins.
    rdv[0] = 32'hA; rdv[3] = 32'hB; wrv = 4'b1001;
    run_txn(4'b1001, 1, 0, 4'b1001, 1'b0, 32'h0600000B);

    // Abort while BUSY.
    pcpi.pcpi_valid = 1'b1;
    pcpi.pcpi_insn  = 32'h0800000B;
    ch_enable       = 4'b0001;
    tick();                             // cycle 1: ISSUE
    ch_wait = 4'b0001;
    tick();                             // cycle 2: BUSY
    tick();                             // cycle 3: BUSY
    chk("abort_busy", 64'(dbg_state), 64'(ST_BUSY));
    pcpi.pcpi_valid = 1'b0;
    tick();                             // cycle 4
    ch_wait = '0;
    chk("abort_chvalid", 64'(ch_valid), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("abort_ready", 64'(pcpi.pcpi_int_ready), 64'd0);
    chk("abort_timeout", 64'(pcpi.pcpi_int_timeout), 64'd0);
    tick();
    chk("abort_ready2", 64'(pcpi.pcpi_int_ready), 64'd0);
    chk("abort_timeout2", 64'(pcpi.pcpi_int_timeout), 64'd0);
    rand_rd();
    run_txn(4'b0110, 3, 0, 4'b0100, 1'b0, 32'h0A00000B);

    // Reset while BUSY.
    pcpi.pcpi_valid = 1'b1;
    pcpi.pcpi_insn  = 32'h0C00000B;
    pcpi.pcpi_rs1   = 32'h1111;
    ch_enable       = 4'b0100;
    tick();
    ch_wait = 4'b0100;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    reset = 1'b0;
    pcpi.pcpi_valid = 1'b0;
    ch_wait = '0;
    exp_err = 1'b0;
    tick();
    rand_rd();
    run_txn(4'b1000, 2, 0, 4'b1000, 1'b0, 32'h0E00000B);

    // Randomized requests.
    for (int t = 0; t < 30; t++) begin
      logic [NCH-1:0] m;
      int r, w;
      m = NCH'($urandom_range(0, 15));
      r = $urandom_range(0, 30);
      w = (r == 0) ? 0 : $urandom_range(0, 3);
      rand_rd();
      run_txn(m, r, w, NCH'($urandom), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/picorv32_pcpi_mux.md
# picorv32_pcpi_mux

Multi-channel PCPI co-processor multiplexer sitting between the picorv32 core's PCPI port and up to NCH co-processors (MUL, DIV, custom). It registers each issued instruction, broadcasts it to the enabled channels, and returns the first response to the core as a single pcpi_int_* result. It also owns the PCPI timeout, which signals an illegal instruction when no channel claims the request.

## Interface
- NCH, 4: number of co-processor channels (1..8)
- XLEN, 32: operand/result width
- TIMEOUT, 16: cycles without any wait/ready before timeout (≥2)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pcpi_valid  in  1  core request valid
- pcpi_insn  in  32  instruction word
- pcpi_rs1, pcpi_rs2  in  XLEN  operands
- pcpi_int_wr  out  1  result writes rd
- pcpi_int_rd  out  XLEN  result
- pcpi_int_wait  out  1  some channel is processing
- pcpi_int_ready  out  1  one-cycle result strobe
- pcpi_int_timeout  out  1  one-cycle timeout strobe
- ch_enable  in  NCH  channel mask, sampled at issue
- ch_valid  out  NCH  per-channel request
- ch_insn  out  32  registered instruction (broadcast)
- ch_rs1, ch_rs2  out  XLEN  registered operands (broadcast)
- ch_wr, ch_wait, ch_ready  in  NCH  per-channel responses
- ch_rd  in  NCH*XLEN  per-channel results; channel i at [i*XLEN +: XLEN]
- err_multi  out  1  sticky protocol error (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE: on pcpi_valid=1, latch insn/rs1/rs2 and mask = ch_enable. Clear the counter, then go to ISSUE. If mask==0, go to DONE and pulse timeout instead.
- ISSUE: ch_valid = mask. The counter increments each cycle with no masked wait/ready.
  - Any masked ch_wait: go to BUSY.
  - Any masked ch_ready: capture the response and go to DONE.
  - Counter reaches TIMEOUT: pulse timeout and go to DONE.
- BUSY: ch_valid held; the counter is frozen. A masked ch_ready captures the response and goes to DONE. There is no timeout in BUSY.
- Capture: winner = lowest-index masked channel with ch_ready=1. Register ch_wr[w] and ch_rd[w]; pcpi_int_ready=1 for exactly one cycle.
- DONE: ch_valid=0; remain until pcpi_valid=0, then go to IDLE. This prevents re-issue of the same instruction.
- Abort: pcpi_valid=0 in ISSUE/BUSY → IDLE next cycle; ch_valid drops and no ready/timeout pulse is issued.
- Unmasked channels' ready/wait/wr/rd are ignored.
- pcpi_int_wait = registered (|(ch_wait & mask)) while in ISSUE/BUSY; otherwise 0.
- Reset (any state, mid-operation included):
  - state → IDLE
  - all outputs 0: ch_valid, pcpi_int_*, latched operands, err_multi
  - counter cleared

## Timing
- Edge 0: pcpi_valid sampled in IDLE. ch_valid/ch_insn/ch_rs* are valid in cycle 1.
- Channel ready in cycle k → pcpi_int_ready/wr/rd valid in cycle k+1. Minimum issue-to-result latency: 2 cycles.
- pcpi_int_wait lags ch_wait by 1 cycle.
- Timeout: no wait/ready during cycles 1..TIMEOUT → pcpi_int_timeout in cycle TIMEOUT+1.
- Simultaneous events:
  - ready and wait in the same cycle: ready wins.
  - ready in the final timeout cycle: ready wins, no timeout.
- pcpi_int_rd/wr hold their value until the next capture; they are meaningful only with ready.

## Configuration
- PCPI_MUX_CHECK_EN defined: err_multi sets (sticky until reset) when either condition occurs:
  - two or more masked channels assert ch_ready in the same cycle, or
  - any unmasked channel asserts ch_ready while ch_valid≠0.
- Without the macro: err_multi is tied 0 and the checker logic is absent. Arbitration is unchanged.

## Test plan
- NCH=4, mask=4'b0010, insn=0x02B50533, ch1 ready in cycle 1 with rd=0x12345678, wr=1 → pcpi_int_ready in cycle 2, rd=0x12345678, wr=1. ch_valid=0 in DONE; return to IDLE after pcpi_valid drops.
- ch2 wait in cycles 1..40, ready in cycle 41 → pcpi_int_wait=1 in cycles 2..41, ready in cycle 42, no timeout.
- TIMEOUT=16, mask=4'b1111, no responses → timeout pulse in cycle 17 only, ready never asserted.
- ch0 and ch3 ready in the same cycle, rd 0xA/0xB → rd=0xA. err_multi=1 with PCPI_MUX_CHECK_EN, 0 without.
- pcpi_valid dropped in cycle 3 of BUSY → ch_valid=0 in cycle 4, no ready/timeout pulse. A new request issues normally afterwards.
- reset asserted in BUSY → next cycle all outputs 0, state IDLE. A following request completes with correct rd.
